// File: rtl/debug_pkg.sv
// Shared debug-unit constants: FSM state encoding and byte/word sizing helpers,
// also used by the debug UART RX command decoder.
package debug_pkg;

    localparam int BYTE_W  = 8;
    localparam int BCNT_W  = 8;
    localparam int NBITS_DEF = 32;
    localparam int BYTES_PER_WORD = NBITS_DEF / BYTE_W;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_SEND = 3'd2,
        ST_DONE = 3'd3,
        ST_CHK  = 3'd4
    } state_t;

    function automatic int bytes_per_word(input int nbits);
        return nbits / BYTE_W;
    endfunction

endpackage

// File: rtl/reg_dump_tx_word_serializer.sv
// Loads one word and emits it LSB byte first over a valid/ready byte stream;
// flags the cycle in which the final byte is accepted.
module word_serializer
    import debug_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load_i,
    input  logic [BCNT_W-1:0]   load_last_i,
    input  logic [NBITS-1:0]    data_i,
    input  logic                ready_i,
    output logic [BYTE_W-1:0]   tx_data_o,
    output logic                tx_valid_o,
    output logic                last_o
);

    logic [NBITS-1:0]  shift_q;
    logic [BCNT_W-1:0] cnt_q;
    logic [BCNT_W-1:0] last_q;
    logic              valid_q;
    logic              fire;

    assign fire       = valid_q & ready_i;
    assign last_o     = fire & (cnt_q == last_q);
    assign tx_data_o  = shift_q[BYTE_W-1:0];
    assign tx_valid_o = valid_q;

    // A load overrides a transfer in the same cycle so the top can chain words.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= data_i;
            cnt_q   <= '0;
            last_q  <= load_last_i;
            valid_q <= 1'b1;
        end else if (fire) begin
            shift_q <= shift_q >> BYTE_W;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == last_q)
                valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Register-file dump streamer: walks registers 0..CELDAS-1 and sends each word
// LSB first. Define REG_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module reg_dump_tx
    import debug_pkg::*;
#(
    parameter int REGS   = 5,
    parameter int NBITS  = 32,
    parameter int CELDAS = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_Start,
    output logic [REGS-1:0]   o_RegDebug,
    input  logic [NBITS-1:0]  i_RegDebugData,
    output logic [7:0]        o_TxData,
    output logic              o_TxValid,
    input  logic              i_TxReady,
    output logic              o_Busy,
    output logic              o_Done
);

    localparam logic [BCNT_W-1:0] WORD_LAST = BCNT_W'(bytes_per_word(NBITS) - 1);
    localparam logic [REGS-1:0]   IDX_LAST  = REGS'(CELDAS - 1);

    state_t            state_q;
    logic [REGS-1:0]   idx_q;
    logic              busy_q;
    logic              done_q;
    logic              ser_load;
    logic [BCNT_W-1:0] ser_load_last;
    logic [NBITS-1:0]  ser_data;
    logic              byte_last;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] acc_q;
    logic              chk_load;

    // The checksum word is loaded as the final data byte leaves, so it must fold that byte in.
    assign chk_load      = (state_q == ST_SEND) & byte_last & (idx_q == IDX_LAST);
    assign ser_load      = (state_q == ST_LOAD) | chk_load;
    assign ser_load_last = (state_q == ST_LOAD) ? WORD_LAST : '0;
    assign ser_data      = (state_q == ST_LOAD) ? i_RegDebugData : NBITS'(acc_q ^ o_TxData);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            acc_q <= '0;
        else if (state_q == ST_IDLE)
            acc_q <= '0;
        else if (o_TxValid & i_TxReady)
            acc_q <= acc_q ^ o_TxData;
    end
`else
    assign ser_load      = (state_q == ST_LOAD);
    assign ser_load_last = WORD_LAST;
    assign ser_data      = i_RegDebugData;
`endif

    word_serializer #(.NBITS(NBITS)) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ser_load),
        .load_last_i (ser_load_last),
        .data_i      (ser_data),
        .ready_i     (i_TxReady),
        .tx_data_o   (o_TxData),
        .tx_valid_o  (o_TxValid),
        .last_o      (byte_last)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    idx_q <= '0;
                    if (i_Start) begin
                        state_q <= ST_LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LOAD: state_q <= ST_SEND;
                ST_SEND: begin
                    if (byte_last) begin
                        if (idx_q == IDX_LAST) begin
`ifdef REG_DUMP_CHECKSUM_EN
                            state_q <= ST_CHK;
`else
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ST_LOAD;
                        end
                    end
                end
                ST_CHK: begin
                    if (byte_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_RegDebug = idx_q;
    assign o_Busy     = busy_q;
    assign o_Done     = done_q;

endmodule

// File: tb/tb_reg_dump_tx.sv
// Self-checking bench for reg_dump_tx against a byte-list model of the dump.
module tb_reg_dump_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_Start;
    logic [4:0]  o_RegDebug;
    logic [31:0] i_RegDebugData;
    logic [7:0]  o_TxData;
    logic        o_TxValid;
    logic        i_TxReady;
    logic        o_Busy;
    logic        o_Done;

    logic [31:0] regs_m [32];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];

    int checks = 0;
    int errors = 0;
    int cyc, done_cnt, done_cyc, last_fire;
    logic stall_prev;
    logic [7:0] stall_data;

    always #5 clk = ~clk;

    assign i_RegDebugData = regs_m[o_RegDebug];

    reg_dump_tx dut (
        .clk            (clk),
        .reset          (reset),
        .i_Start        (i_Start),
        .o_RegDebug     (o_RegDebug),
        .i_RegDebugData (i_RegDebugData),
        .o_TxData       (o_TxData),
        .o_TxValid      (o_TxValid),
        .i_TxReady      (i_TxReady),
        .o_Busy         (o_Busy),
        .o_Done         (o_Done)
    );

    // Expected stream: every register, least significant byte first, optional XOR tail.
    task automatic build_expected();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(regs_m[r][8*b +: 8]);
                x = x ^ regs_m[r][8*b +: 8];
            end
`ifdef REG_DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // One clock: sample at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (stall_prev) begin
            checks++;
            if (o_TxValid !== 1'b1 || o_TxData !== stall_data) begin
                errors++;
                $display("FAIL hold cyc=%0d valid=%b data=%02h required valid=1 data=%02h",
                         cyc, o_TxValid, o_TxData, stall_data);
            end
        end
        stall_prev = o_TxValid && !i_TxReady;
        stall_data = o_TxData;
        if (o_TxValid === 1'b1 && i_TxReady === 1'b1) begin
            got.push_back(o_TxData);
            last_fire = cyc;
        end
        if (o_Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs();
        got.delete();
        cyc = 0; done_cnt = 0; done_cyc = -1; last_fire = -1;
        stall_prev = 1'b0; stall_data = 8'h00;
    endtask

    task automatic run_dump(input int ready_pct, input int restart_at);
        bit restarted;
        restarted = 0;
        i_Start   = 1'b1;
        i_TxReady = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            tick();
            i_Start = 1'b0;
            if (done_cnt > 0) break;
            if (restart_at >= 0 && !restarted && o_RegDebug == 5'(restart_at)) begin
                i_Start   = 1'b1;
                restarted = 1;
            end
            i_TxReady = (ready_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ready_pct);
        end
        i_TxReady = 1'b1;
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout done_cnt=0 required >=1");
        end
    endtask

    task automatic compare_seq(input string name);
        int bad, first;
        bad = 0; first = -1;
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s_len got=%0d required=%0d", name, got.size(), exp_q.size());
        end
        checks++;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        if (bad != 0) begin
            errors++;
            $display("FAIL %s_bytes mismatches=%0d first idx=%0d got=%02h required=%02h",
                     name, bad, first, got[first], exp_q[first]);
        end
        $display("%s: %0d bytes, done at cycle %0d", name, got.size(), done_cyc);
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (o_TxValid !== 1'b0 || o_TxData !== 8'h00 || o_Busy !== 1'b0 ||
            o_Done !== 1'b0 || o_RegDebug !== 5'd0) begin
            errors++;
            $display("FAIL %s valid=%b data=%02h busy=%b done=%b idx=%0d required all 0",
                     name, o_TxValid, o_TxData, o_Busy, o_Done, o_RegDebug);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_Start = 1'b0; i_TxReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset_state");
        reset = 1'b1;
        clear_obs();
        repeat (2) tick();
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_full_dump();
        int exp_done;
        for (int r = 0; r < 32; r++) regs_m[r] = 32'(r);
        build_expected();
        clear_obs();
        run_dump(100, -1);
        compare_seq("full_dump");
`ifdef REG_DUMP_CHECKSUM_EN
        exp_done = 163;
`else
        exp_done = 162;
`endif
        checks++;
        if (done_cyc != exp_done) begin
            errors++;
            $display("FAIL full_done_cycle got=%0d required=%0d", done_cyc, exp_done);
        end
        tick();
        checks++;
        if (o_Busy !== 1'b0 || o_Done !== 1'b0) begin
            errors++;
            $display("FAIL full_after busy=%b done=%b required 0 0", o_Busy, o_Done);
        end
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 32; r++) regs_m[r] = $urandom;
        build_expected();
        clear_obs();
        run_dump(30, -1);
        compare_seq("backpressure");
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL bp_done_count got=%0d required=1", done_cnt);
        end
    endtask

    task automatic test_restart_ignored();
        for (int r = 0; r < 32; r++) regs_m[r] = $urandom;
        build_expected();
        clear_obs();
        run_dump(100, 10);
        repeat (20) tick();
        compare_seq("restart_ignored");
        checks++;
        if (done_cnt != 1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL restart_done_count got=%0d busy=%b required 1 0", done_cnt, o_Busy);
        end
    endtask

    task automatic test_reset_abort();
        for (int r = 0; r < 32; r++) regs_m[r] = $urandom | 32'h0000_0001;
        clear_obs();
        i_Start = 1'b1; i_TxReady = 1'b1;
        for (int i = 0; i < 300 && got.size() < 29; i++) begin
            tick();
            i_Start = 1'b0;
        end
        checks++;
        if (o_RegDebug !== 5'd7 || o_TxValid !== 1'b1) begin
            errors++;
            $display("FAIL abort_position idx=%0d valid=%b required 7 1", o_RegDebug, o_TxValid);
        end
        reset = 1'b0;
        #1;
        check_idle_outputs("abort_async");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        build_expected();
        clear_obs();
        run_dump(100, -1);
        compare_seq("after_abort");
    endtask

    task automatic test_checksum_data();
        for (int r = 0; r < 32; r++) regs_m[r] = 32'h0;
        regs_m[5] = 32'hDEADBEEF;
        build_expected();
        clear_obs();
        run_dump(100, -1);
        compare_seq("checksum_data");
        checks++;
        if (got.size() < 24 || got[20] !== 8'hEF || got[21] !== 8'hBE ||
            got[22] !== 8'hAD || got[23] !== 8'hDE) begin
            errors++;
            $display("FAIL reg5_bytes size=%0d required EF BE AD DE at 20..23", got.size());
        end
`ifdef REG_DUMP_CHECKSUM_EN
        checks++;
        if (got.size() != 129 || got[128] !== 8'h22) begin
            errors++;
            $display("FAIL checksum_byte size=%0d required 129 bytes ending 22", got.size());
        end
`else
        checks++;
        if (got.size() != 128) begin
            errors++;
            $display("FAIL byte_count got=%0d required=128", got.size());
        end
`endif
        checks++;
        if (done_cyc != last_fire + 1) begin
            errors++;
            $display("FAIL done_after_last got=%0d required=%0d", done_cyc, last_fire + 1);
        end
    endtask

    initial begin
        test_reset();
        test_full_dump();
        test_backpressure();
        test_restart_ignored();
        test_reset_abort();
        test_checksum_data();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
